// File: rtl/ramp_adc_averager.sv
// Merges the two ramp-ADC sample streams, averages blocks of 2**AVG_LOG2 samples
// and queues results in a valid/ready FIFO. Define RAMP_ADC_MINMAX_EN to add per-block min/max.
module ramp_adc_averager #(
  parameter int NBITS      = 8,
  parameter int AVG_LOG2   = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          enable_i,
  input  logic                          clear_i,
  input  logic [NBITS-1:0]              adc_value_0_i,
  input  logic                          adc_valid_0_i,
  input  logic [NBITS-1:0]              adc_value_1_i,
  input  logic                          adc_valid_1_i,
  output logic [NBITS-1:0]              data_o,
  output logic                          valid_o,
  input  logic                          ready_i,
  output logic [$clog2(FIFO_DEPTH):0]   level_o,
  output logic                          overflow_o,
  output logic [NBITS-1:0]              min_o,
  output logic [NBITS-1:0]              max_o
);

  localparam int AW = NBITS + AVG_LOG2 + 1;
  localparam int CW = AVG_LOG2 + 1;
  localparam int N  = 1 << AVG_LOG2;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int LW = PW + 1;
`ifdef RAMP_ADC_MINMAX_EN
  localparam int EW = 3 * NBITS;
`else
  localparam int EW = NBITS;
`endif

  logic [AW-1:0]    acc_reg, acc_next, acc_a, acc_b, sum;
  logic [CW-1:0]    cnt_reg, cnt_next, cnt_a, cnt_b;
  logic             take_a, take_b, done_a, done_b, first_b, push;
  logic [NBITS-1:0] s_a;
  logic [EW-1:0]    entry;
  logic [EW-1:0]    mem [FIFO_DEPTH];
  logic [PW-1:0]    wr_ptr_reg, rd_ptr_reg;
  logic [LW-1:0]    level_reg, level_next;
  logic             overflow_reg, full, empty, pop, wr_en, ovf_set;
  logic [EW-1:0]    head;
`ifdef RAMP_ADC_MINMAX_EN
  logic [NBITS-1:0] min_reg, max_reg, min_a, max_a, min_b, max_b, res_min, res_max;
`endif

  // Samples are folded in two ordered steps (first accepted sample, then ch1 when
  // both arrive), so a block completed by ch0 lets ch1 seed the next block.
  always_comb begin
    take_a = enable_i & (adc_valid_0_i | adc_valid_1_i);
    take_b = enable_i & adc_valid_0_i & adc_valid_1_i;
    s_a    = adc_valid_0_i ? adc_value_0_i : adc_value_1_i;
    acc_a  = acc_reg;
    cnt_a  = cnt_reg;
    if (take_a) begin
      acc_a = acc_reg + AW'(s_a);
      cnt_a = cnt_reg + CW'(1);
    end
    done_a  = take_a && (cnt_a == CW'(N));
    acc_b   = done_a ? '0 : acc_a;
    cnt_b   = done_a ? '0 : cnt_a;
    first_b = (cnt_b == '0);
    if (take_b) begin
      acc_b = acc_b + AW'(adc_value_1_i);
      cnt_b = cnt_b + CW'(1);
    end
    done_b   = take_b && (cnt_b == CW'(N));
    push     = done_a | done_b;
    sum      = done_a ? acc_a : acc_b;
    acc_next = done_b ? '0 : acc_b;
    cnt_next = done_b ? '0 : cnt_b;
`ifdef RAMP_ADC_MINMAX_EN
    min_a = min_reg;
    max_a = max_reg;
    if (take_a) begin
      min_a = ((cnt_reg == '0) || (s_a < min_reg)) ? s_a : min_reg;
      max_a = ((cnt_reg == '0) || (s_a > max_reg)) ? s_a : max_reg;
    end
    min_b = min_a;
    max_b = max_a;
    if (take_b) begin
      min_b = (first_b || (adc_value_1_i < min_a)) ? adc_value_1_i : min_a;
      max_b = (first_b || (adc_value_1_i > max_a)) ? adc_value_1_i : max_a;
    end
    res_min = done_a ? min_a : min_b;
    res_max = done_a ? max_a : max_b;
    entry   = {res_max, res_min, NBITS'(sum >> AVG_LOG2)};
`else
    entry   = NBITS'(sum >> AVG_LOG2);
`endif
  end

  assign empty   = (level_reg == '0);
  assign full    = (level_reg == LW'(FIFO_DEPTH));
  assign pop     = ~empty & ready_i;
  assign wr_en   = push & (~full | pop);
  assign ovf_set = push & full & ~pop;

  always_comb begin
    level_next = level_reg;
    case ({wr_en, pop})
      2'b10:   level_next = level_reg + LW'(1);
      2'b01:   level_next = level_reg - LW'(1);
      default: level_next = level_reg;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      acc_reg      <= '0;
      cnt_reg      <= '0;
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      level_reg    <= '0;
      overflow_reg <= 1'b0;
    end else if (clear_i) begin
      acc_reg      <= '0;
      cnt_reg      <= '0;
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      level_reg    <= '0;
      overflow_reg <= 1'b0;
    end else begin
      acc_reg   <= acc_next;
      cnt_reg   <= cnt_next;
      level_reg <= level_next;
      if (wr_en)   wr_ptr_reg   <= wr_ptr_reg + PW'(1);
      if (pop)     rd_ptr_reg   <= rd_ptr_reg + PW'(1);
      if (ovf_set) overflow_reg <= 1'b1;
    end
  end

`ifdef RAMP_ADC_MINMAX_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      min_reg <= '0;
      max_reg <= '0;
    end else if (clear_i) begin
      min_reg <= '0;
      max_reg <= '0;
    end else begin
      min_reg <= min_b;
      max_reg <= max_b;
    end
  end
`endif

  // Storage needs no reset: entries are only visible while level is non-zero.
  always_ff @(posedge clk_i) begin
    if (wr_en && !clear_i) mem[wr_ptr_reg] <= entry;
  end

  assign head       = mem[rd_ptr_reg];
  assign valid_o    = ~empty;
  assign level_o    = level_reg;
  assign overflow_o = overflow_reg;
  assign data_o     = valid_o ? head[NBITS-1:0] : '0;
`ifdef RAMP_ADC_MINMAX_EN
  assign min_o      = valid_o ? head[2*NBITS-1:NBITS] : '0;
  assign max_o      = valid_o ? head[3*NBITS-1:2*NBITS] : '0;
`else
  assign min_o      = '0;
  assign max_o      = '0;
`endif

endmodule

// File: tb/tb_ramp_adc_averager.sv
// Randomised and directed bench for ramp_adc_averager against a queue-based block/FIFO model.
module tb_ramp_adc_averager;
  localparam int NBITS = 8;
  localparam int AVG_LOG2 = 2;
  localparam int DEPTH = 4;
  localparam int N = 1 << AVG_LOG2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic enable = 1'b0, clear = 1'b0, ready = 1'b0;
  logic [7:0] d0 = '0, d1 = '0;
  logic v0 = 1'b0, v1 = 1'b0;
  logic [7:0] data_o, min_o, max_o;
  logic valid_o, overflow_o;
  logic [2:0] level_o;

  int pass_cnt = 0;
  int total_cnt = 0;
  bit compare_on = 0;

  typedef struct {int avg; int mn; int mx;} res_t;
  int   blk[$];
  res_t exp_q[$];
  bit   m_ovf;

  ramp_adc_averager #(.NBITS(NBITS), .AVG_LOG2(AVG_LOG2), .FIFO_DEPTH(DEPTH)) dut (
    .clk_i(clk), .rst_ni(rst_n), .enable_i(enable), .clear_i(clear),
    .adc_value_0_i(d0), .adc_valid_0_i(v0), .adc_value_1_i(d1), .adc_valid_1_i(v1),
    .data_o(data_o), .valid_o(valid_o), .ready_i(ready), .level_o(level_o),
    .overflow_o(overflow_o), .min_o(min_o), .max_o(max_o));

  always #5 clk = ~clk;

  task automatic chk(string nm, int act, int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
  endtask

  task automatic model_reset();
    blk.delete();
    exp_q.delete();
    m_ovf = 0;
  endtask

  task automatic model_add(int v, inout bit have, inout res_t r);
    int s, mn, mx;
    blk.push_back(v);
    if (blk.size() == N) begin
      s = 0; mn = blk[0]; mx = blk[0];
      foreach (blk[i]) begin
        s += blk[i];
        if (blk[i] < mn) mn = blk[i];
        if (blk[i] > mx) mx = blk[i];
      end
      r.avg = s / N; r.mn = mn; r.mx = mx;
      have = 1;
      blk.delete();
    end
  endtask

  task automatic model_step();
    bit pop, full, have;
    res_t r;
    if (!rst_n) return;
    pop = (exp_q.size() > 0) && ready;
    if (clear) begin
      model_reset();
      return;
    end
    have = 0; r = '{0, 0, 0};
    full = (exp_q.size() == DEPTH);
    if (enable) begin
      if (v0) model_add(int'(d0), have, r);
      if (v1) model_add(int'(d1), have, r);
    end
    if (pop) void'(exp_q.pop_front());
    if (have) begin
      if (!full || pop) exp_q.push_back(r);
      else m_ovf = 1;
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // Outputs are stable between negedge and the following posedge.
  initial forever begin
    @(negedge clk);
    if (compare_on) begin
      chk("valid", int'(valid_o), int'(exp_q.size() > 0));
      chk("data", int'(data_o), (exp_q.size() > 0) ? exp_q[0].avg : 0);
      chk("level", int'(level_o), exp_q.size());
      chk("overflow", int'(overflow_o), int'(m_ovf));
`ifdef RAMP_ADC_MINMAX_EN
      chk("min", int'(min_o), (exp_q.size() > 0) ? exp_q[0].mn : 0);
      chk("max", int'(max_o), (exp_q.size() > 0) ? exp_q[0].mx : 0);
`else
      chk("min", int'(min_o), 0);
      chk("max", int'(max_o), 0);
`endif
    end
  end

  task automatic cyc(bit e, bit a0, int x0, bit a1, int x1, bit r, bit c);
    @(negedge clk); #1;
    enable = e; v0 = a0; d0 = 8'(x0); v1 = a1; d1 = 8'(x1); ready = r; clear = c;
  endtask

  task automatic idle(bit r); cyc(1, 0, 0, 0, 0, r, 0); endtask
  task automatic s0(int x); cyc(1, 1, x, 0, 0, 0, 0); endtask
  task automatic s1(int x); cyc(1, 0, 0, 1, x, 0, 0); endtask
  task automatic pop_one(); idle(1); idle(0); endtask
  task automatic do_clear(); cyc(1, 0, 0, 0, 0, 0, 1); idle(0); endtask

  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b1;
    compare_on = 1;
    // 1: idle after reset
    repeat (20) idle(0);
    chk("reset_valid", int'(valid_o), 0);
    chk("reset_level", int'(level_o), 0);

    // 2: basic average and truncation
    s0(10); s0(20); s0(30); s0(40);
    chk("latency_before", int'(valid_o), 0);
    idle(0);
    chk("avg25_data", int'(data_o), 25);
    chk("avg25_level", int'(level_o), 1);
    s0(1); s0(1); s0(1); s0(2); idle(0);
    chk("two_entries", int'(level_o), 2);
    pop_one();
    chk("trunc_data", int'(data_o), 1);
    pop_one();
    chk("drained", int'(level_o), 0);

    // 3: split rule and both-at-N-2
    s0(100); s0(100); s0(100); cyc(1, 1, 100, 1, 200, 0, 0);
    s1(200); s1(200); s1(200); idle(0);
    chk("split_level", int'(level_o), 2);
    chk("split_first", int'(data_o), 100);
    pop_one();
    chk("split_second", int'(data_o), 200);
    pop_one();
    s0(4); s0(4); cyc(1, 1, 8, 1, 12, 0, 0); idle(0);
    chk("pair_done", int'(data_o), 7);
    pop_one();

    // 4: overflow and ordered drain
    for (int b = 0; b < 5; b++) for (int i = 0; i < N; i++) s0(10 * (b + 1));
    idle(0);
    chk("full_level", int'(level_o), 4);
    chk("ovf_set", int'(overflow_o), 1);
    for (int i = 0; i < 4; i++) begin
      chk("drain_order", int'(data_o), 10 * (i + 1));
      pop_one();
    end
    chk("drain_empty", int'(level_o), 0);
    chk("ovf_sticky", int'(overflow_o), 1);
    do_clear();
    chk("ovf_cleared", int'(overflow_o), 0);

    // 5: clear discards partial block and concurrent sample
    s0(50); s0(60); cyc(1, 1, 99, 0, 0, 0, 1);
    s0(8); s0(8); s0(8); s0(8); idle(0);
    chk("after_clear_level", int'(level_o), 1);
    chk("after_clear_data", int'(data_o), 8);
    pop_one();

    // 6: enable low, then push+pop at full
    repeat (3) cyc(0, 1, 33, 1, 44, 0, 0);
    idle(0);
    chk("disabled_level", int'(level_o), 0);
    for (int b = 0; b < 4; b++) for (int i = 0; i < N; i++) s0(20);
    s0(40); s0(40); s0(40); cyc(1, 1, 40, 0, 0, 1, 0); idle(0);
    chk("pushpop_level", int'(level_o), 4);
    chk("pushpop_ovf", int'(overflow_o), 0);
    do_clear();

    // Random traffic with varying backpressure and one mid-run async reset
    for (int c = 0; c < 3000; c++) begin
      int rp;
      rp = (c / 500) % 3;
      if (c == 1500) begin
        @(negedge clk); #1;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("async_rst_valid", int'(valid_o), 0);
        chk("async_rst_level", int'(level_o), 0);
        @(negedge clk); #1 rst_n = 1'b1;
      end
      cyc(($urandom % 8) != 0, $urandom % 2, $urandom % 256, $urandom % 2, $urandom % 256,
          rp == 0 ? ($urandom % 8 == 0) : rp == 1 ? ($urandom % 2 == 1) : ($urandom % 8 != 0),
          ($urandom % 97) == 0);
    end
    idle(0);
    @(negedge clk);
    compare_on = 0;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
